// File: rtl/bl_zone_spi_tx_pkg.sv
// Shared constants and FSM encoding for the zone-backlight SPI transmitter.
package bl_zone_spi_tx_pkg;

  localparam int BL_ZONES  = 360;
  localparam int BL_DATA_W = 8;
  localparam int BL_ADDR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

endpackage

// File: rtl/bl_zone_spi_tx_if.sv
// Zone-value stream from the 360-zone analysis block into the transmitter.
interface bl_zone_spi_tx_if;
  import bl_zone_spi_tx_pkg::*;

  logic [BL_ADDR_W-1:0] cnt_360;
  logic                 flag_done;
  logic [BL_DATA_W-1:0] buf_360_flatted;

  modport master (output cnt_360, flag_done, buf_360_flatted);
  modport slave  (input  cnt_360, flag_done, buf_360_flatted);
endinterface

// File: rtl/bl_zone_ram.sv
// Ping-pong zone buffer: two banks of ZONES bytes, one write port, one
// registered read port.
module bl_zone_ram
  import bl_zone_spi_tx_pkg::*;
#(
  parameter int ZONES  = BL_ZONES,
  parameter int DATA_W = BL_DATA_W
) (
  input  logic                 i_pix_clk,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [BL_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en,
  input  logic                 rd_bank,
  input  logic [BL_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] mem [2][ZONES];

  // NOTE: no reset on the array or read register so the tools can map this
  // onto block RAM; every byte is written before a frame reads it.
  always_ff @(posedge i_pix_clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/bl_zone_spi_tx.sv
// Captures zone values into a ping-pong buffer and, on each vsync rising edge,
// shifts the completed frame out MSB-first over an SPI-style link with a latch.
module bl_zone_spi_tx
  import bl_zone_spi_tx_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic            i_pix_clk,
  input  logic            rst_n,
  bl_zone_spi_tx_if.slave zone_if,
  input  logic            r_Vsync_0,
  input  logic            tx_enable,
  output logic            o_sclk,
  output logic            o_sdo,
  output logic            o_lat,
  output logic            o_busy,
  output logic            o_frame_drop
);

  state_e               state;
  logic                 wr_bank;
  logic [BL_ADDR_W-1:0] addr;
  logic [3:0]           div_cnt;
  logic                 half;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift_q;
  logic                 load_pending;
  logic                 vs_q, vs_q2;
  logic [7:0]           rd_data;

  logic vs_edge, div_end, end_high, wr_en;

  assign vs_edge  = vs_q & ~vs_q2;
  assign div_end  = (div_cnt == 4'(CLK_DIV - 1));
  assign end_high = (state == ST_SHIFT) && half && div_end;
  assign wr_en    = zone_if.flag_done && (zone_if.cnt_360 < BL_ADDR_W'(BL_ZONES));

  bl_zone_ram #(.ZONES(BL_ZONES), .DATA_W(BL_DATA_W)) u_ram (
    .i_pix_clk (i_pix_clk),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_addr   (zone_if.cnt_360),
    .wr_data   (zone_if.buf_360_flatted),
    .rd_en     (state == ST_LOAD),
    .rd_bank   (~wr_bank),
    .rd_addr   (addr),
    .rd_data   (rd_data)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wr_bank      <= 1'b0;
      addr         <= '0;
      div_cnt      <= '0;
      half         <= 1'b0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      load_pending <= 1'b0;
      vs_q         <= 1'b0;
      vs_q2        <= 1'b0;
      o_sclk       <= 1'b0;
      o_sdo        <= 1'b0;
      o_lat        <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_drop <= 1'b0;
    end else begin
      vs_q         <= r_Vsync_0;
      vs_q2        <= vs_q;
      o_frame_drop <= vs_edge && tx_enable && (state != ST_IDLE);

      // Serial pins are a one-cycle-delayed image of the FSM; o_busy tracks
      // the state itself so it rises in the first LOAD cycle.
      unique case (state)
        ST_IDLE: begin
          o_sclk <= 1'b0;
          o_sdo  <= 1'b0;
          o_lat  <= 1'b0;
          if (vs_edge && tx_enable) begin
            wr_bank <= ~wr_bank;
            addr    <= '0;
            o_busy  <= 1'b1;
            state   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          o_sclk       <= 1'b0;
          o_sdo        <= 1'b0;
          div_cnt      <= '0;
          half         <= 1'b0;
          bit_cnt      <= '0;
          load_pending <= 1'b1;
          state        <= ST_SHIFT;
        end

        ST_SHIFT: begin
          o_sclk <= half;
          if (load_pending) begin
            // First cycle of the byte: RAM data has just arrived.
            shift_q      <= rd_data;
            o_sdo        <= rd_data[7];
            load_pending <= 1'b0;
          end else begin
            o_sdo <= end_high ? shift_q[6] : shift_q[7];
          end

          div_cnt <= div_end ? 4'd0 : div_cnt + 4'd1;
          if (div_end) half <= ~half;

          if (end_high) begin
            shift_q <= {shift_q[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr == BL_ADDR_W'(BL_ZONES - 1)) begin
                state <= ST_LATCH;
              end else begin
                addr  <= addr + 1'b1;
                state <= ST_LOAD;
              end
            end
          end
        end

        ST_LATCH: begin
          o_sclk  <= 1'b0;
          o_sdo   <= 1'b0;
          o_lat   <= 1'b1;
          div_cnt <= div_end ? 4'd0 : div_cnt + 4'd1;
          if (div_end) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bl_zone_spi_tx.sv
// Directed bench for bl_zone_spi_tx: bank model + byte scoreboard on o_sclk rises.
module tb_bl_zone_spi_tx;
  import bl_zone_spi_tx_pkg::*;

  logic i_pix_clk = 1'b0;
  logic rst_n;
  logic r_Vsync_0, tx_enable;
  logic o_sclk, o_sdo, o_lat, o_busy, o_frame_drop;

  bl_zone_spi_tx_if zif ();

  bl_zone_spi_tx #(.CLK_DIV(2)) dut (
    .i_pix_clk    (i_pix_clk),
    .rst_n        (rst_n),
    .zone_if      (zif),
    .r_Vsync_0    (r_Vsync_0),
    .tx_enable    (tx_enable),
    .o_sclk       (o_sclk),
    .o_sdo        (o_sdo),
    .o_lat        (o_lat),
    .o_busy       (o_busy),
    .o_frame_drop (o_frame_drop)
  );

  always #5 i_pix_clk = ~i_pix_clk;

  int cyc = 0;
  always @(posedge i_pix_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of both banks and the expected byte stream.
  logic [7:0] bank_m [2][BL_ZONES];
  int         wb_m = 0;
  logic [7:0] exp_q [$];

  // Monitor: counters only ever grow; the sequence compares deltas.
  int         mon_bits = 0, rx_bytes = 0, sclk_rises = 0;
  int         busy_cycles = 0, busy_rise_cyc = -1;
  int         lat_cycles = 0, lat_rises = 0;
  int         drop_rises = 0, drop_cyc = -1;
  logic [7:0] mon_sh = '0, last_byte = '0, exp_b;
  logic       p_sclk = 1'b0, p_busy = 1'b0, p_lat = 1'b0, p_drop = 1'b0;

  always @(negedge i_pix_clk) begin
    if (!rst_n) begin
      mon_bits = 0;
      p_sclk   = 1'b0;
    end else begin
      if (o_sclk && !p_sclk) begin
        sclk_rises++;
        mon_sh = {mon_sh[6:0], o_sdo};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits  = 0;
          rx_bytes++;
          last_byte = mon_sh;
          check("sb_depth", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check("sb_byte", {24'd0, mon_sh}, {24'd0, exp_b});
          end
        end
      end
      p_sclk = o_sclk;
    end
    if (o_busy) busy_cycles++;
    if (o_busy && !p_busy) busy_rise_cyc = cyc;
    if (o_lat) lat_cycles++;
    if (o_lat && !p_lat) lat_rises++;
    if (o_frame_drop && !p_drop) begin
      drop_rises++;
      drop_cyc = cyc;
    end
    p_busy = o_busy;
    p_lat  = o_lat;
    p_drop = o_frame_drop;
  end

  task automatic zone_write(input int a, input logic [7:0] d);
    @(posedge i_pix_clk); #1;
    zif.flag_done       = 1'b1;
    zif.cnt_360         = 9'(a);
    zif.buf_360_flatted = d;
    if (a < BL_ZONES) bank_m[wb_m][a] = d;
  endtask

  task automatic zone_clear();
    @(posedge i_pix_clk); #1;
    zif.flag_done = 1'b0;
  endtask

  // Raises vsync; the edge cycle is the one after the DUT registers it.
  task automatic vsync_rise(output int edge_cyc);
    @(posedge i_pix_clk); #1;
    r_Vsync_0 = 1'b1;
    edge_cyc  = cyc + 1;
  endtask

  task automatic vsync_fall();
    repeat (3) @(posedge i_pix_clk);
    #1 r_Vsync_0 = 1'b0;
  endtask

  task automatic launch_frame();
    for (int i = 0; i < BL_ZONES; i++) exp_q.push_back(bank_m[wb_m][i]);
    wb_m ^= 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge i_pix_clk); #1;
      n++;
    end while (o_busy && n < 13000);
    check("wait_idle_timeout", 32'(o_busy), 32'd0);
    repeat (5) @(posedge i_pix_clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sclk"}, 32'(o_sclk), 32'd0);
    check({tag, "_sdo"},  32'(o_sdo),  32'd0);
    check({tag, "_lat"},  32'(o_lat),  32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_drop"}, 32'(o_frame_drop), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2, n3, n5, n6;
    int b_busy, b_lat, b_latr, b_drop, b_rx, b_sclk, wait_n;

    rst_n = 1'b0; r_Vsync_0 = 1'b0; tx_enable = 1'b1;
    zif.flag_done = 1'b0; zif.cnt_360 = '0; zif.buf_360_flatted = '0;
    repeat (3) @(posedge i_pix_clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;

    // Frame 1: ramp into bank 0, send it; mid-frame vsync must be dropped.
    for (int i = 0; i < BL_ZONES; i++) zone_write(i, 8'(i));
    zone_clear();
    b_busy = busy_cycles; b_lat = lat_cycles; b_latr = lat_rises;
    b_drop = drop_rises; b_rx = rx_bytes;
    vsync_rise(n1);
    launch_frame();
    vsync_fall();
    for (int i = 0; i < BL_ZONES; i++) zone_write(i, 8'(i * 3 + 7));
    zone_clear();
    do begin
      @(posedge i_pix_clk); #1;
    end while (cyc < n1 + 4999);
    r_Vsync_0 = 1'b1;
    n2 = cyc + 1;
    vsync_fall();
    wait_idle();
    check("f1_busy_rise", 32'(busy_rise_cyc), 32'(n1 + 1));
    check("f1_busy_len",  32'(busy_cycles - b_busy), 32'd11882);
    check("f1_lat_pulses", 32'(lat_rises - b_latr), 32'd1);
    check("f1_lat_len",   32'(lat_cycles - b_lat), 32'd2);
    check("f1_drop_pulses", 32'(drop_rises - b_drop), 32'd1);
    check("f1_drop_cycle", 32'(drop_cyc), 32'(n2 + 1));
    check("f1_bytes", 32'(rx_bytes - b_rx), 32'd360);
    check("f1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-range write is ignored; same-cycle write joins the sent frame.
    zone_write(400, 8'hFF);
    zone_clear();
    b_drop = drop_rises; b_rx = rx_bytes;
    vsync_rise(n3);
    zone_write(359, 8'hA5);
    zone_clear();
    launch_frame();
    vsync_fall();
    wait_idle();
    check("f2_last_byte", {24'd0, last_byte}, 32'h0000_00A5);
    check("f2_bytes", 32'(rx_bytes - b_rx), 32'd360);
    check("f2_sb_empty", 32'(exp_q.size()), 32'd0);
    check("f2_no_drop", 32'(drop_rises - b_drop), 32'd0);

    // Disabled: vsync edge must be ignored entirely.
    tx_enable = 1'b0;
    b_busy = busy_cycles; b_sclk = sclk_rises; b_drop = drop_rises;
    vsync_rise(n5);
    vsync_fall();
    repeat (60) @(posedge i_pix_clk);
    #1;
    check("dis_busy", 32'(busy_cycles - b_busy), 32'd0);
    check("dis_sclk", 32'(sclk_rises - b_sclk), 32'd0);
    check("dis_drop", 32'(drop_rises - b_drop), 32'd0);
    tx_enable = 1'b1;

    // Reset at byte 100 of a frame from bank 0.
    b_rx = rx_bytes;
    vsync_rise(n6);
    launch_frame();
    vsync_fall();
    wait_n = 0;
    do begin
      @(posedge i_pix_clk); #1;
      wait_n++;
    end while (rx_bytes < b_rx + 100 && wait_n < 5000);
    check("rst_wait_timeout", 32'(rx_bytes - b_rx >= 100), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    exp_q.delete();
    wb_m = 0;
    repeat (3) @(posedge i_pix_clk);
    #1 rst_n = 1'b1;
    b_busy = busy_cycles; b_latr = lat_rises;
    repeat (100) @(posedge i_pix_clk);
    #1;
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_busy_cycles", 32'(busy_cycles - b_busy), 32'd0);
    check("post_rst_no_lat", 32'(lat_rises - b_latr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
